rggen_bit_field_wo_ext: RTL
===========================

RGGEN_BIT_FIELD_WO_EXT -- requirements
Module: rggen_bit_field_wo_ext

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit-field width in bits, 1..64.
REQ-002 SHALL have parameter INITIAL_VALUE, default '0, WIDTH bits: reset and idle value.
REQ-003 SHALL have parameter MODE, default 0: 0=HOLD, 1=ONCE, 2=PULSE; any other value is an elaboration error.
REQ-004 SHALL have parameter PULSE_CYCLES, default 1: PULSE-mode assertion length, 1..255.
REQ-005 SHALL have parameter DEPTH, default 2: notification queue depth, 1..16.
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 SHALL have port i_clk  input  1  clock; all state updates on its rising edge.
REQ-008 SHALL have port i_rst  input  1  synchronous active-high reset.
REQ-009 SHALL have port bit_field_if  modport rggen_bit_field_if.bit_field  uses valid, write_data, write_mask, read_data, value.
REQ-010 SHALL have port o_value  output  WIDTH  current field value.
REQ-011 SHALL have port o_write_valid  output  1  notification queue non-empty.
REQ-012 SHALL have port o_write_data  output  WIDTH  queue head value.
REQ-013 SHALL have port i_write_ready  input  1  downstream accepts the head.
REQ-014 SHALL have port o_overflow  output  1  sticky: a notification was dropped.

Function
REQ-015 SHALL define an accepted write as bit_field_if.valid high in a cycle where the MODE rules below admit it.
REQ-016 SHALL define merged = (write_data & write_mask) | (value & ~write_mask).
REQ-017 SHALL drive bit_field_if.read_data to all zeros at all times; the field is write-only.
REQ-018 SHALL drive bit_field_if.value and o_value from the same register.
REQ-019 In HOLD mode, SHALL load value <= merged on every valid write; the new value is visible 1 cycle later.
REQ-020 In ONCE mode, SHALL accept only the first valid write after reset, then set an internal lock flag.
REQ-021 In ONCE mode with the lock flag set, SHALL ignore further writes: no value change, no queue push.
REQ-022 In PULSE mode, on a valid write SHALL load value <= merged and load the counter with PULSE_CYCLES.
REQ-023 In PULSE mode, SHALL decrement the counter each cycle while it is nonzero; on the 1->0 transition value returns to INITIAL_VALUE the next cycle, so the value is held exactly PULSE_CYCLES cycles.
REQ-024 In PULSE mode, a write during an active pulse SHALL reload the counter and merge against the current value.
REQ-025 Every accepted write SHALL push the post-write value into the queue (FIFO order), including writes with write_mask all zero.
REQ-026 SHALL assert o_write_valid while the queue is non-empty, with o_write_data the oldest entry.
REQ-027 SHALL pop the head when o_write_valid && i_write_ready.
REQ-028 SHALL keep o_write_data stable while o_write_valid=1 and i_write_ready=0.
REQ-029 On a push to a full queue without a same-cycle pop, SHALL drop the new entry and set o_overflow.
REQ-030 On a push and pop in the same cycle, SHALL complete both and leave the occupancy unchanged, including when the queue is full; no overflow is raised.
REQ-031 SHALL wrap the read and write pointers modulo DEPTH, with no bubble cycles.

Reset
REQ-032 While i_rst=1, SHALL set value=INITIAL_VALUE, counter=0, lock flag=0, queue empty, o_write_valid=0, o_write_data=0, o_overflow=0.
REQ-033 Reset SHALL override a write in the same cycle; a pulse or queue contents in flight are discarded.
REQ-034 o_overflow SHALL clear only on reset.

Configuration
REQ-035 Macro RGGEN_BIT_FIELD_WO_EXT_QUEUE_EN defined SHALL compile in the notification queue per REQ-025..031.
REQ-036 Without the macro, SHALL compile out the queue storage, tie o_write_valid, o_write_data and o_overflow to 0, and ignore i_write_ready; all value behaviour is unchanged.

Verification
REQ-037 HOLD, WIDTH=8, INITIAL=0x00: write 0xA5 with mask 0x0F -> value 0x05 next cycle; read_data stays 0x00.
REQ-038 ONCE: write 0x3C, then write 0xFF -> value stays 0x3C; exactly one queue entry (0x3C).
REQ-039 PULSE, PULSE_CYCLES=3, INITIAL=0: write 0x01 -> value 0x01 for exactly 3 cycles, then 0x00; a rewrite at cycle 2 extends it to 5 cycles total.
REQ-040 Queue, DEPTH=2, i_write_ready=0: writes 0x11, 0x22, 0x33 -> o_overflow=1; release ready -> heads 0x11 then 0x22; 0x33 lost.
REQ-041 Queue full, i_write_ready=1 and a write in the same cycle -> push and pop both occur, o_overflow stays 0.
REQ-042 i_rst=1 asserted mid-pulse with a non-empty queue -> next cycle value=INITIAL, o_write_valid=0, o_overflow=0.

Source files
------------

// File: rtl/rggen_bit_field_wo_ext_if.sv
// Register-bus side of a single bit field: write strobe/data/mask in, read data and value out.
interface rggen_bit_field_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport master (
    output valid, write_data, write_mask,
    input  read_data, value
  );

  modport bit_field (
    input  valid, write_data, write_mask,
    output read_data, value
  );
endinterface

// File: rtl/rggen_bit_field_wo_ext.sv
// Write-only bit field with HOLD/ONCE/PULSE modes and an optional write-notification queue.
// Define RGGEN_BIT_FIELD_WO_EXT_QUEUE_EN to build the notification queue; otherwise its outputs are tied low.
module rggen_bit_field_wo_ext #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
  parameter int               MODE          = 0,
  parameter int               PULSE_CYCLES  = 1,
  parameter int               DEPTH         = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  rggen_bit_field_if.bit_field  bit_field_if,
  output logic [WIDTH-1:0]      o_value,
  output logic                  o_write_valid,
  output logic [WIDTH-1:0]      o_write_data,
  input  logic                  i_write_ready,
  output logic                  o_overflow
);
  localparam int MODE_HOLD  = 0;
  localparam int MODE_ONCE  = 1;
  localparam int MODE_PULSE = 2;

  if (MODE < MODE_HOLD || MODE > MODE_PULSE) begin : g_bad_mode
    $error("rggen_bit_field_wo_ext: MODE must be 0, 1 or 2");
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("rggen_bit_field_wo_ext: WIDTH must be 1..64");
  end
  if (PULSE_CYCLES < 1 || PULSE_CYCLES > 255) begin : g_bad_pulse
    $error("rggen_bit_field_wo_ext: PULSE_CYCLES must be 1..255");
  end
  if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
    $error("rggen_bit_field_wo_ext: DEPTH must be 1..16");
  end

  logic [WIDTH-1:0] value_reg;
  logic [7:0]       counter_reg;
  logic             lock_reg;
  logic [WIDTH-1:0] merged;
  logic             accept;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_merge
    assign merged[gi] = bit_field_if.write_mask[gi] ? bit_field_if.write_data[gi] : value_reg[gi];
  end

  // Once locked, ONCE mode behaves as if no write ever arrived.
  assign accept = bit_field_if.valid && ((MODE != MODE_ONCE) || !lock_reg);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      value_reg   <= INITIAL_VALUE;
      counter_reg <= '0;
      lock_reg    <= 1'b0;
    end else if (accept) begin
      value_reg <= merged;
      if (MODE == MODE_ONCE) begin
        lock_reg <= 1'b1;
      end
      if (MODE == MODE_PULSE) begin
        counter_reg <= 8'(PULSE_CYCLES);
      end
    end else if ((MODE == MODE_PULSE) && (counter_reg != '0)) begin
      counter_reg <= counter_reg - 8'd1;
      if (counter_reg == 8'd1) begin
        value_reg <= INITIAL_VALUE;
      end
    end
  end

  assign bit_field_if.read_data = '0;
  assign bit_field_if.value     = value_reg;
  assign o_value                = value_reg;

`ifdef RGGEN_BIT_FIELD_WO_EXT_QUEUE_EN
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             overflow_reg;
  logic             pop;
  logic             full;
  logic             push_ok;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop     = (count_reg != '0) && i_write_ready;
  assign full    = (count_reg == CW'(DEPTH));
  // A same-cycle pop frees the slot, so a full queue still takes the new entry.
  assign push_ok = accept && (!full || pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst && push_ok) begin
      mem[wr_ptr_reg] <= merged;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wrap_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= wrap_inc(rd_ptr_reg);
      end
      count_reg <= count_reg + CW'(push_ok) - CW'(pop);
      if (accept && !push_ok) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign o_write_valid = (count_reg != '0);
  assign o_write_data  = o_write_valid ? mem[rd_ptr_reg] : '0;
  assign o_overflow    = overflow_reg;
`else
  logic unused_write_ready;
  assign unused_write_ready = i_write_ready;
  assign o_write_valid      = 1'b0;
  assign o_write_data       = '0;
  assign o_overflow         = 1'b0;
`endif
endmodule
